skeeball_ball_detect: RTL and testbench

Front-end conditioning stage for the skeeball score path. It synchronizes and debounces the seven raw hole sensors and arbitrates simultaneous hits. It emits exactly one single-cycle one-hot hit pulse per ball, which the score accumulator consumes directly. It also owns the game state: start, balls remaining, and game over.

---
 rtl/skeeball_ball_detect_if.sv | 31 +++
 rtl/skeeball_ball_detect.sv | 140 ++++++++++++++
 tb/tb_skeeball_ball_detect.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skeeball_ball_detect_if.sv
// Sensor-side and game-state signals of the skeeball ball detector.
// The bench drives the master side. The detector uses the slave side.
interface skeeball_ball_detect_if;
    logic       start;
    logic [6:0] sens;
    logic [6:0] hit;
    logic       ball_valid;
    logic [3:0] balls_left;
    logic       game_active;
    logic       game_over;

    modport master (
        output start,
        output sens,
        input  hit,
        input  ball_valid,
        input  balls_left,
        input  game_active,
        input  game_over
    );

    modport slave (
        input  start,
        input  sens,
        output hit,
        output ball_valid,
        output balls_left,
        output game_active,
        output game_over
    );
endinterface

// File: rtl/skeeball_ball_detect.sv
// Synchronizes, debounces and arbitrates the seven hole sensors.
// Emits one one-hot hit pulse per ball and runs the IDLE/PLAY/OVER game state.
module skeeball_ball_detect #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BALLS_PER_GAME  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    skeeball_ball_detect_if.slave bus
);
    localparam int         SENS_W     = 7;
    localparam logic [7:0] CNT_MAX    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] BALLS_INIT = 4'(BALLS_PER_GAME);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    logic [SENS_W-1:0] sync_p0;
    logic [SENS_W-1:0] sync_p1;
    logic [SENS_W-1:0] db_p2;
    logic [7:0]        cnt_p2 [SENS_W];
    logic [SENS_W-1:0] db_dly_p3;
    logic [SENS_W-1:0] cand;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        balls;
    logic [3:0]        balls_nxt;
    logic [SENS_W-1:0] hit_q;
    logic [SENS_W-1:0] hit_nxt;
    logic              vld_q;

    // Keeps only the highest-valued candidate so the output stays one-hot.
    function automatic logic [SENS_W-1:0] pick_highest(input logic [SENS_W-1:0] c);
        logic [SENS_W-1:0] r;
        r = '0;
        for (int i = 0; i < SENS_W; i++) begin
            if (c[i]) r = SENS_W'(1) << i;
        end
        return r;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizer.
    // Stage p2: per-bit debounce. The state flips only after CNT_MAX+1 differing cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_p2   <= '0;
            for (int i = 0; i < SENS_W; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            sync_p0 <= bus.sens;
            sync_p1 <= sync_p0;
            for (int i = 0; i < SENS_W; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_MAX) begin
                    db_p2[i]  <= sync_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 8'd1;
                end
            end
        end
    end

    // Stage p3: delayed debounced state used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_dly_p3 <= '0;
        end else begin
            db_dly_p3 <= db_p2;
        end
    end

    assign cand = db_p2 & ~db_dly_p3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            balls <= '0;
            hit_q <= '0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            balls <= balls_nxt;
            hit_q <= hit_nxt;
            vld_q <= |hit_nxt;
        end
    end

    // A start in PLAY restarts the game and drops any candidate in the same cycle.
    always_comb begin
        state_nxt = state;
        balls_nxt = balls;
        hit_nxt   = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = PLAY;
                    balls_nxt = BALLS_INIT;
                end
            end
            PLAY: begin
                if (bus.start) begin
                    balls_nxt = BALLS_INIT;
                end else if ((cand != '0) && (balls != 4'd0)) begin
                    hit_nxt   = pick_highest(cand);
                    balls_nxt = sat_dec(balls);
                    if (balls == 4'd1) state_nxt = OVER;
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_nxt = PLAY;
                    balls_nxt = BALLS_INIT;
                end
            end
            default: begin
                state_nxt = IDLE;
                balls_nxt = '0;
            end
        endcase
    end

    assign bus.hit         = hit_q;
    assign bus.ball_valid  = vld_q;
    assign bus.balls_left  = balls;
    assign bus.game_active = (state == PLAY);
    assign bus.game_over   = (state == OVER);
endmodule

// File: tb/tb_skeeball_ball_detect.sv
// Directed and randomized bench for skeeball_ball_detect.
// A behavioural game model predicts every output after every clock edge.
module tb_skeeball_ball_detect;
    localparam int D   = 16;
    localparam int BPG = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hits_seen = 0;
    int   first_hit_cyc = -1;
    logic [6:0] last_hit = '0;

    skeeball_ball_detect_if bus ();

    skeeball_ball_detect #(.DEBOUNCE_CYCLES(D), .BALLS_PER_GAME(BPG)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state: raw history, debounced levels with run lengths, game mode 0=idle 1=play 2=over.
    bit [6:0] m_raw1, m_raw2, m_db, m_dbprev, m_hit;
    int       m_run [7];
    int       m_mode = 0;
    int       m_balls = 0;

    task automatic model_edge(input bit rn, input bit st, input bit [6:0] raw);
        bit [6:0] rising, db_next, pick;
        bit       found;
        if (!rn) begin
            m_raw1 = '0; m_raw2 = '0; m_db = '0; m_dbprev = '0; m_hit = '0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
            m_mode = 0;
            m_balls = 0;
            return;
        end
        rising  = m_db & ~m_dbprev;
        db_next = m_db;
        for (int i = 0; i < 7; i++) begin
            if (m_raw2[i] != m_db[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    db_next[i] = m_raw2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        pick = '0;
        found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (rising[i] && !found) begin
                pick[i] = 1'b1;
                found = 1'b1;
            end
        end
        m_hit = '0;
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_balls = BPG; end
        end else if (m_mode == 1) begin
            if (st) m_balls = BPG;
            else if (found) begin
                m_hit = pick;
                m_balls = m_balls - 1;
                if (m_balls == 0) m_mode = 2;
            end
        end else begin
            if (st) begin m_mode = 1; m_balls = BPG; end
        end
        m_dbprev = m_db;
        m_db     = db_next;
        m_raw2   = m_raw1;
        m_raw1   = raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst_n, bus.start, bus.sens);
        #1;
        cyc++;
        chk("hit", 32'(bus.hit), 32'(m_hit));
        chk("ball_valid", 32'(bus.ball_valid), 32'(m_hit != 0));
        chk("balls_left", 32'(bus.balls_left), 32'(m_balls));
        chk("game_active", 32'(bus.game_active), 32'(m_mode == 1));
        chk("game_over", 32'(bus.game_over), 32'(m_mode == 2));
        if (bus.hit != '0) begin
            hits_seen++;
            last_hit = bus.hit;
            if (first_hit_cyc < 0) first_hit_cyc = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_hits();
        hits_seen = 0;
        first_hit_cyc = -1;
        last_hit = '0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse(input logic [6:0] bits, input int hi, input int lo);
        bus.sens = bits;
        steps(hi);
        bus.sens = '0;
        steps(lo);
    endtask

    initial begin
        int base;
        int dur;
        logic [31:0] r;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sens = '0;
        steps(3);
        chk("reset_hit", 32'(bus.hit), 32'h0);
        chk("reset_balls", 32'(bus.balls_left), 32'h0);
        rst_n = 1'b1;
        step();

        // Test 1: single held sensor, latency and one-cycle pulse.
        start_pulse();
        chk("t1_start_balls", 32'(bus.balls_left), 32'd9);
        chk("t1_active", 32'(bus.game_active), 32'd1);
        clear_hits();
        base = cyc;
        bus.sens = 7'b0100000;
        steps(40);
        chk("t1_latency", 32'(first_hit_cyc - base), 32'(D + 3));
        chk("t1_count", 32'(hits_seen), 32'd1);
        chk("t1_value", 32'(last_hit), 32'h20);
        chk("t1_balls", 32'(bus.balls_left), 32'd8);
        bus.sens = '0;
        steps(25);

        // Test 2: short glitch ignored, exactly-D pulse accepted.
        clear_hits();
        pulse(7'b0001000, 10, 30);
        chk("t2_glitch_count", 32'(hits_seen), 32'd0);
        chk("t2_glitch_balls", 32'(bus.balls_left), 32'd8);
        pulse(7'b0001000, D, 30);
        chk("t2_pulse_count", 32'(hits_seen), 32'd1);
        chk("t2_pulse_value", 32'(last_hit), 32'h08);
        chk("t2_pulse_balls", 32'(bus.balls_left), 32'd7);

        // Test 3: simultaneous rise, highest bit wins.
        clear_hits();
        pulse(7'b1000100, 30, 30);
        chk("t3_count", 32'(hits_seen), 32'd1);
        chk("t3_value", 32'(last_hit), 32'h40);
        chk("t3_balls", 32'(bus.balls_left), 32'd6);

        // Test 4: full game of gutter-adjacent balls, then suppression in OVER.
        start_pulse();
        chk("t4_restart_balls", 32'(bus.balls_left), 32'd9);
        clear_hits();
        for (int b = 0; b < 9; b++) pulse(7'b0000010, 30, 30);
        chk("t4_count", 32'(hits_seen), 32'd9);
        chk("t4_balls", 32'(bus.balls_left), 32'd0);
        chk("t4_over", 32'(bus.game_over), 32'd1);
        chk("t4_active", 32'(bus.game_active), 32'd0);
        clear_hits();
        pulse(7'b0000010, 30, 30);
        chk("t4_tenth", 32'(hits_seen), 32'd0);

        // Test 5: start from OVER, then start colliding with a candidate.
        start_pulse();
        chk("t5_over_cleared", 32'(bus.game_over), 32'd0);
        chk("t5_reload", 32'(bus.balls_left), 32'd9);
        for (int b = 0; b < 5; b++) begin
            r = $urandom_range(0, 6);
            pulse(7'(1) << r[2:0], 30, 30);
        end
        chk("t5_four_left", 32'(bus.balls_left), 32'd4);
        clear_hits();
        bus.sens = 7'b0010000;
        steps(D + 2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t5_dropped_hit", 32'(bus.hit), 32'h0);
        chk("t5_restart_balls", 32'(bus.balls_left), 32'd9);
        steps(30);
        chk("t5_no_late_hit", 32'(hits_seen), 32'd0);
        bus.sens = '0;
        steps(30);

        // Randomized sensor activity with occasional starts and resets.
        for (int it = 0; it < 60; it++) begin
            r = $urandom;
            bus.sens = 7'(r) & 7'(r >> 7);
            dur = $urandom_range(1, 40);
            for (int k = 0; k < dur; k++) begin
                r = $urandom;
                bus.start = (r[3:0] == 4'd0);
                rst_n = (r[11:4] != 8'd0);
                step();
            end
            bus.start = 1'b0;
            rst_n = 1'b1;
        end
        bus.sens = '0;
        steps(30);

        // Test 6: reset mid-game and mid-debounce, then a held sensor.
        start_pulse();
        bus.sens = 7'b0100000;
        steps(8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_hit", 32'(bus.hit), 32'h0);
        chk("t6_rst_balls", 32'(bus.balls_left), 32'd0);
        chk("t6_rst_active", 32'(bus.game_active), 32'd0);
        chk("t6_rst_over", 32'(bus.game_over), 32'd0);
        clear_hits();
        steps(60);
        start_pulse();
        steps(40);
        chk("t6_held_no_hit", 32'(hits_seen), 32'd0);
        pulse(7'b0000000, 30, 0);
        pulse(7'b0100000, 30, 30);
        chk("t6_fresh_count", 32'(hits_seen), 32'd1);
        chk("t6_fresh_value", 32'(last_hit), 32'h20);
        chk("t6_balls", 32'(bus.balls_left), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
